// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Merges the two issue-slot write ports into one register-file write port.
// Accepted writes go into an in-order circular buffer, which drains one entry
// per cycle. Pending values are forwarded to the read stage.
// Issue stalls whenever the buffer might not hold two more writes.
module regfile_write_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    output logic                       stall,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_addr,
    output logic [DATA_W-1:0]          rf_data,
    input  logic [ADDR_W-1:0]          rd_addr1,
    input  logic [ADDR_W-1:0]          rd_addr2,
    output logic                       byp_hit1,
    output logic [DATA_W-1:0]          byp_data1,
    output logic                       byp_hit2,
    output logic [DATA_W-1:0]          byp_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_acc;
    logic              w_v0;
    logic              w_v1;
    logic              w_pop;
    logic [PW-1:0]     w_slot1;

    // Stall depends only on state, so it can gate acceptance without creating a loop.
    assign stall   = (r_count >= CW'(DEPTH - 1));
    assign w_acc   = ~stall;
    assign w_pop   = (r_count != '0);

    // Slot 0 is dropped when slot 1 writes the same register, because the younger value wins.
    assign w_v0    = w_acc & wr0_en & (wr0_addr != '0) & ~(wr1_en & (wr1_addr == wr0_addr));
    assign w_v1    = w_acc & wr1_en & (wr1_addr != '0);
    assign w_slot1 = w_v0 ? r_tail + PW'(1) : r_tail;

    assign rf_we   = w_pop;
    assign rf_addr = w_pop ? r_addr[r_head] : '0;
    assign rf_data = w_pop ? r_data[r_head] : '0;
    assign count   = r_count;
    assign empty   = (r_count == '0);

    // Pointer and occupancy bookkeeping, with enqueue and pop allowed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_v0) + PW'(w_v1);
            r_count <= r_count + CW'(w_v0) + CW'(w_v1) - CW'(w_pop);
        end
    end

    // Entry payload storage, which needs no reset because the count qualifies every read.
    always_ff @(posedge clk) begin
        if (w_v0) begin
            r_addr[r_tail]  <= wr0_addr;
            r_data[r_tail]  <= wr0_data;
        end
        if (w_v1) begin
            r_addr[w_slot1] <= wr1_addr;
            r_data[w_slot1] <= wr1_data;
        end
    end

    // Bypass search, walking oldest to newest so that the newest match overrides older ones.
    always_comb begin
        logic [PW-1:0] w_idx;
        byp_hit1  = 1'b0;
        byp_data1 = '0;
        byp_hit2  = 1'b0;
        byp_data2 = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if ((rd_addr1 != '0) && (r_addr[w_idx] == rd_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = r_data[w_idx];
                end
                if ((rd_addr2 != '0) && (r_addr[w_idx] == rd_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = r_data[w_idx];
                end
            end
        end
    end

endmodule
